// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity encodings, receiver states,
// and the baud-divider computation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BREAK
    } state_t;

    // Clocks per oversample tick, rounded to the nearest integer.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, with a
// synchronous clear so the tick phase can be re-aligned to a line edge.
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote per
// bit, start-glitch rejection, configurable width/parity/stop bits.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 SerialIn,
    output logic [DATA_BITS-1:0] ReceivedData,
    output logic                 UpdatePulse,
    output logic                 ParityError,
    output logic                 FrameError,
    output logic                 Busy
);

    localparam int DIV      = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int BIT_W    = 4;

    localparam logic [SAMPLE_W-1:0] TICK_A    = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] TICK_B    = SAMPLE_W'(OVERSAMPLE / 2);
    localparam logic [SAMPLE_W-1:0] TICK_MID  = SAMPLE_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMPLE_W-1:0] TICK_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]    LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]    LAST_STOP = BIT_W'(STOP_BITS - 1);

    state_t state, state_next;

    logic                 sync_meta;
    logic                 line;
    logic                 tick;
    logic                 start_det;
    logic                 mid_tick;
    logic                 end_tick;
    logic                 voted;
    logic                 frame_done;
    logic [SAMPLE_W-1:0]  sample_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc;
    logic                 par_err_acc;
    logic                 frame_err_acc;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_err_q;
    logic                 frame_err_q;
    logic                 pulse_q;

    // Line is idle high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
        end else begin
            sync_meta <= SerialIn;
            line      <= sync_meta;
        end
    end

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (Clock),
        .rst_n(Reset),
        .clear(start_det),
        .tick (tick)
    );

    assign start_det  = (state == ST_IDLE) && !line;
    assign mid_tick   = tick && (sample_cnt == TICK_MID);
    assign end_tick   = tick && (sample_cnt == TICK_LAST);
    assign voted      = majority3(samp_a, samp_b, line);
    assign frame_done = (state == ST_STOP) && mid_tick && (bit_cnt == LAST_STOP);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!line) state_next = ST_START;
            ST_START: begin
                if (mid_tick && voted)  state_next = ST_IDLE;
                else if (end_tick)      state_next = ST_DATA;
            end
            ST_DATA:  begin
                if (end_tick && bit_cnt == LAST_DATA)
                    state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end
            ST_PAR:   if (end_tick) state_next = ST_STOP;
            ST_STOP:  if (frame_done) state_next = voted ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (line) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            samp_a        <= 1'b0;
            samp_b        <= 1'b0;
            shift_reg     <= '0;
            par_acc       <= 1'b0;
            par_err_acc   <= 1'b0;
            frame_err_acc <= 1'b0;
            data_q        <= '0;
            par_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            pulse_q <= frame_done;

            if (start_det)
                sample_cnt <= '0;
            else if (tick)
                sample_cnt <= (sample_cnt == TICK_LAST) ? '0 : sample_cnt + 1'b1;

            // Bit index restarts whenever the FSM moves to a new field.
            if (state_next != state)
                bit_cnt <= '0;
            else if (end_tick)
                bit_cnt <= bit_cnt + 1'b1;

            if (tick && sample_cnt == TICK_A) samp_a <= line;
            if (tick && sample_cnt == TICK_B) samp_b <= line;

            if (start_det) begin
                par_acc       <= 1'b0;
                par_err_acc   <= 1'b0;
                frame_err_acc <= 1'b0;
            end

            if (state == ST_DATA && mid_tick) begin
                shift_reg <= {voted, shift_reg[DATA_BITS-1:1]};
                par_acc   <= par_acc ^ voted;
            end

            if (state == ST_PAR && mid_tick)
                par_err_acc <= (PARITY == PAR_ODD) ? !(par_acc ^ voted) : (par_acc ^ voted);

            if (state == ST_STOP && mid_tick && !voted)
                frame_err_acc <= 1'b1;

            if (frame_done) begin
                data_q      <= shift_reg;
                par_err_q   <= par_err_acc;
                frame_err_q <= frame_err_acc | !voted;
            end
        end
    end

    assign ReceivedData = data_q;
    assign UpdatePulse  = pulse_q;
    assign ParityError  = par_err_q;
    assign FrameError   = frame_err_q;
    assign Busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: three instances (8N1, 8E1, 7N2)
// driven with directed frames; a monitor pops expectations on each UpdatePulse.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 160;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] line;

    logic [7:0] rd0, rd1;
    logic [6:0] rd2;
    logic       up0, pe0, fe0, bz0;
    logic       up1, pe1, fe1, bz1;
    logic       up2, pe2, fe2, bz2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int   checks = 0;
    int   errors = 0;
    logic [2:0] prev_pulse = 3'b000;

    uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                          .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .Clock(clk), .Reset(rst_n), .SerialIn(line[0]), .ReceivedData(rd0),
        .UpdatePulse(up0), .ParityError(pe0), .FrameError(fe0), .Busy(bz0));

    uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                          .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
        .Clock(clk), .Reset(rst_n), .SerialIn(line[1]), .ReceivedData(rd1),
        .UpdatePulse(up1), .ParityError(pe1), .FrameError(fe1), .Busy(bz1));

    uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                          .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7n2 (
        .Clock(clk), .Reset(rst_n), .SerialIn(line[2]), .ReceivedData(rd2),
        .UpdatePulse(up2), .ParityError(pe2), .FrameError(fe2), .Busy(bz2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic score(input int idx, input logic [8:0] data, input logic perr, input logic ferr);
        exp_t e;
        int   n;
        n = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
        check($sformatf("pulse_expected_%0d", idx), 32'(n != 0), 32'd1);
        if (n != 0) begin
            case (idx)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("data_%0d", idx), 32'(data), 32'(e.data));
            check($sformatf("parity_err_%0d", idx), 32'(perr), 32'(e.perr));
            check($sformatf("frame_err_%0d", idx), 32'(ferr), 32'(e.ferr));
        end
    endtask

    task automatic expect_frame(input int idx, input logic [8:0] data, input logic perr, input logic ferr);
        exp_t e;
        e.data = data;
        e.perr = perr;
        e.ferr = ferr;
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Drives start, data (LSB first), optional parity and stop bits on line[idx].
    task automatic send_frame(input int idx, input logic [8:0] data, input int dbits,
                              input bit has_par, input logic par_bit,
                              input int nstop, input logic stop_val);
        logic [15:0] f;
        int          n;
        f    = '1;
        f[0] = 1'b0;
        n    = 1;
        for (int i = 0; i < dbits; i++) begin
            f[n] = data[i];
            n++;
        end
        if (has_par) begin
            f[n] = par_bit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            f[n] = stop_val;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            line[idx] = f[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (prev_pulse[0]) check("pulse_width_0", 32'(up0), 32'd0);
        if (prev_pulse[1]) check("pulse_width_1", 32'(up1), 32'd0);
        if (prev_pulse[2]) check("pulse_width_2", 32'(up2), 32'd0);
        if (up0) score(0, {1'b0, rd0}, pe0, fe0);
        if (up1) score(1, {1'b0, rd1}, pe1, fe1);
        if (up2) score(2, {2'b00, rd2}, pe2, fe2);
        prev_pulse <= {up2, up1, up0};
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line  = 3'b111;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data_0",  32'(rd0), 32'd0);
        check("rst_pulse_0", 32'(up0), 32'd0);
        check("rst_perr_0",  32'(pe0), 32'd0);
        check("rst_ferr_0",  32'(fe0), 32'd0);
        check("rst_busy_0",  32'(bz0), 32'd0);
        check("rst_data_1",  32'(rd1), 32'd0);
        check("rst_busy_1",  32'(bz1), 32'd0);
        check("rst_data_2",  32'(rd2), 32'd0);
        check("rst_busy_2",  32'(bz2), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 basic frame
        expect_frame(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        check("busy_after_a5", 32'(bz0), 32'd0);

        // Start-bit glitch shorter than half a bit
        line[0] = 1'b0;
        repeat (40) @(negedge clk);
        line[0] = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_busy", 32'(bz0), 32'd0);
        check("glitch_data", 32'(rd0), 32'h0A5);
        check("glitch_ferr", 32'(fe0), 32'd0);
        check("glitch_perr", 32'(pe0), 32'd0);

        // Framing error followed by a held-low line
        expect_frame(0, 9'h055, 1'b0, 1'b1);
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("break_busy", 32'(bz0), 32'd1);
        line[0] = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("break_exit_busy", 32'(bz0), 32'd0);
        expect_frame(0, 9'h012, 1'b0, 1'b0);
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);

        // Even parity: 0x03 needs parity bit 0
        expect_frame(1, 9'h003, 1'b1, 1'b0);
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
        expect_frame(1, 9'h003, 1'b0, 1'b0);
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);

        // One-clock reset during data bit 3 of 0xFF
        fork
            send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (4 * BIT_CLKS + 40) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("midrst_data", 32'(rd0), 32'd0);
        check("midrst_perr", 32'(pe0), 32'd0);
        check("midrst_ferr", 32'(fe0), 32'd0);
        check("midrst_busy", 32'(bz0), 32'd0);
        expect_frame(0, 9'h03C, 1'b0, 1'b0);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);

        // 7N2 back-to-back frames
        expect_frame(2, 9'h011, 1'b0, 1'b0);
        expect_frame(2, 9'h022, 1'b0, 1'b0);
        expect_frame(2, 9'h07F, 1'b0, 1'b0);
        send_frame(2, 9'h011, 7, 1'b0, 1'b0, 2, 1'b1);
        send_frame(2, 9'h022, 7, 1'b0, 1'b0, 2, 1'b1);
        send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 2, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("busy_after_7n2", 32'(bz2), 32'd0);

        check("pending_0", 32'(q0.size()), 32'd0);
        check("pending_1", 32'(q1.size()), 32'd0);
        check("pending_2", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
